uart_tx_engine: RTL and testbench
=================================

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have ports: UARTCLK  in  1  sole clock; all state changes on its rising edge.
REQ-002 SHALL have: nUARTRST  in  1  reset, synchronous, active-low.
REQ-003 SHALL have: i_en  in  1  transmit enable (UARTEN & TXE).
REQ-004 SHALL have: i_ibrd  in  16  integer baud divisor; i_fbrd  in  6  fractional divisor in 1/64 units.
REQ-005 SHALL have: i_wlen  in  2  word length (00=5, 01=6, 10=7, 11=8 bits); i_pen  in  1  parity enable; i_eps  in  1  even parity select; i_sps  in  1  stick parity; i_stp2  in  1  two stop bits.
REQ-006 SHALL have: i_brk  in  1  send break.
REQ-007 SHALL have: s_valid  in  1, s_data  in  8, s_ready  out  1  byte input handshake.
REQ-008 SHALL have: UARTTXD  out  1  serial line, registered; o_busy  out  1  frame in progress; o_done  out  1  one-cycle frame-complete pulse.

Function
REQ-009 SHALL assert s_ready = (state==IDLE) & i_en & ~i_brk & (i_ibrd!=0); transfer occurs on a cycle where s_valid & s_ready.
REQ-010 SHALL latch s_data, i_wlen, i_pen, i_eps, i_sps, i_stp2, i_ibrd and i_fbrd on transfer; input changes mid-frame SHALL NOT affect the current frame.
REQ-011 SHALL generate a baud16 tick from a down-counter: on transfer load IBRD-1 and clear the 6-bit accumulator; tick when the counter is 0; on each tick compute {carry,acc} = acc + FBRD and reload IBRD-1+carry.
REQ-012 SHALL time each bit as exactly 16 ticks, using a 4-bit sub-counter; a bit advances on the tick where the sub-counter equals 15.
REQ-013 SHALL implement states IDLE -> START -> DATA -> [PARITY if pen] -> STOP1 -> [STOP2 if stp2] -> IDLE.
REQ-014 SHALL drive UARTTXD: IDLE 1 (0 if i_brk), START 0, DATA LSB first for wlen bits (upper bits ignored), PARITY computed bit, STOP 1.
REQ-015 SHALL compute parity: sps=1 -> ~eps; sps=0, eps=1 -> XOR of the data bits (even); sps=0, eps=0 -> XNOR of the data bits (odd).
REQ-016 SHALL make UARTTXD reflect the START bit in the cycle after transfer; a frame of N bits occupies 16*N ticks.
REQ-017 SHALL assert o_busy whenever state!=IDLE.
REQ-018 SHALL pulse o_done for one cycle in the first IDLE cycle after the last stop bit; s_ready may be high in that same cycle, so back-to-back frames have exactly 1 idle-high cycle between them.
REQ-019 SHALL complete an in-progress frame normally if i_en falls or i_brk rises mid-frame; no new transfer is accepted afterwards.
REQ-020 SHALL drive UARTTXD 0 while i_brk=1 in IDLE, and return it to 1 the cycle after i_brk falls.
REQ-021 SHALL hold the divider when i_ibrd==0 at IDLE (no transfer is possible).

Reset
REQ-022 SHALL, while nUARTRST=0 at a clock edge, set state IDLE, UARTTXD=1, o_busy=0, o_done=0, counters and accumulator 0; s_ready SHALL be 0 while nUARTRST=0.
REQ-023 SHALL abort any frame on reset mid-operation; no o_done is issued for the aborted frame.

Verification
REQ-024 IBRD=1, FBRD=0, 8N1, send 0x55 at cycle k -> TXD 0 during k+1..k+16, then 1,0,1,0,1,0,1,0 at 16 cycles each, stop 1 for 16 cycles, o_done at k+161.
REQ-025 IBRD=1, 7E1 (wlen=10, pen=1, eps=1), data 0x41 -> 7 data bits 1000001 LSB first, parity 0, o_done at k+161.
REQ-026 IBRD=2, FBRD=32, 8N1 -> tick periods 2,2,3,2,3...; o_done at k+400.
REQ-027 i_brk=1 during data bit 3 -> frame completes, UARTTXD=0 and s_ready=0 from the first IDLE cycle; i_brk=0 -> TXD=1 and s_ready=1 the next cycle.
REQ-028 5O2 with stick parity (sps=1, eps=0), nUARTRST low during data bit 2 -> next edge TXD=1, o_busy=0, no o_done; a new byte after release transmits correctly.
REQ-029 i_en=0 mid-frame -> frame finishes with o_done; s_ready stays 0 until i_en=1.

Source files
------------

// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   Serialises one byte per handshake as a UART frame:
//   start, 5..8 data bits LSB first, optional parity, 1 or 2 stop bits.
//   Bit time is 16 baud16 ticks. The tick period comes from an integer
//   divisor plus a 6-bit fractional accumulator.
// Ports
//   UARTCLK, nUARTRST      clock, synchronous active-low reset
//   i_en                   transmit enable
//   i_ibrd, i_fbrd         integer divisor, fractional divisor (1/64)
//   i_wlen, i_pen, i_eps,  frame format: word length, parity enable,
//   i_sps, i_stp2          even parity, stick parity, two stop bits
//   i_brk                  hold line low while idle
//   s_valid/s_data/s_ready byte input handshake
//   UARTTXD                registered serial output
//   o_busy, o_done         frame in progress, frame-complete pulse
module uart_tx_engine (
   input  logic        UARTCLK,
   input  logic        nUARTRST,
   input  logic        i_en,
   input  logic [15:0] i_ibrd,
   input  logic [5:0]  i_fbrd,
   input  logic [1:0]  i_wlen,
   input  logic        i_pen,
   input  logic        i_eps,
   input  logic        i_sps,
   input  logic        i_stp2,
   input  logic        i_brk,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   output logic        s_ready,
   output logic        UARTTXD,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2
   } state_t;

   state_t      r_state;
   logic [7:0]  r_data;
   logic [1:0]  r_wlen;
   logic        r_pen, r_eps, r_sps, r_stp2;
   logic [15:0] r_ibrd;
   logic [5:0]  r_fbrd;
   logic [15:0] r_cnt;
   logic [5:0]  r_acc;
   logic [3:0]  r_sub;
   logic [2:0]  r_bit;
   logic        r_txd;
   logic        r_done;

   logic        w_xfer;
   logic        w_tick;
   logic        w_bit_end;
   logic        w_last;
   logic [6:0]  w_accsum;
   logic [15:0] w_reload;
   logic [7:0]  w_ones;
   logic [7:0]  w_dmask;
   logic        w_par;

   assign s_ready   = nUARTRST && (r_state == S_IDLE) && i_en && !i_brk &&
                      (i_ibrd != 16'd0);
   assign w_xfer    = s_valid && s_ready;

   // The divider only runs inside a frame, so it is frozen while idle.
   assign w_tick    = (r_state != S_IDLE) && (r_cnt == 16'd0);
   assign w_bit_end = w_tick && (r_sub == 4'hF);
   assign w_accsum  = {1'b0, r_acc} + {1'b0, r_fbrd};
   // A fractional carry stretches the next tick period by one clock.
   assign w_reload  = r_ibrd - 16'd1 + {15'd0, w_accsum[6]};

   // Last data bit index is 4+wlen, i.e. {1, wlen}.
   assign w_last    = (r_bit == {1'b1, r_wlen});

   // Parity covers only the bits actually transmitted.
   assign w_ones    = 8'hFF;
   assign w_dmask   = r_data & (w_ones >> (2'd3 - r_wlen));
   assign w_par     = r_sps ? ~r_eps : (r_eps ? ^w_dmask : ~^w_dmask);

   always_ff @(posedge UARTCLK) begin
      if (!nUARTRST) begin
         r_state <= S_IDLE;
         r_data  <= '0;
         r_wlen  <= '0;
         r_pen   <= 1'b0;
         r_eps   <= 1'b0;
         r_sps   <= 1'b0;
         r_stp2  <= 1'b0;
         r_ibrd  <= '0;
         r_fbrd  <= '0;
         r_cnt   <= '0;
         r_acc   <= '0;
         r_sub   <= '0;
         r_bit   <= '0;
         r_txd   <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (r_state == S_IDLE) begin
            r_txd <= ~i_brk;
            if (w_xfer) begin
               r_data  <= s_data;
               r_wlen  <= i_wlen;
               r_pen   <= i_pen;
               r_eps   <= i_eps;
               r_sps   <= i_sps;
               r_stp2  <= i_stp2;
               r_ibrd  <= i_ibrd;
               r_fbrd  <= i_fbrd;
               r_cnt   <= i_ibrd - 16'd1;
               r_acc   <= '0;
               r_sub   <= '0;
               r_bit   <= '0;
               r_state <= S_START;
               r_txd   <= 1'b0;
            end
         end else begin
            if (w_tick) begin
               r_acc <= w_accsum[5:0];
               r_cnt <= w_reload;
               r_sub <= r_sub + 4'd1;
            end else begin
               r_cnt <= r_cnt - 16'd1;
            end
            if (w_bit_end) begin
               case (r_state)
                  S_START: begin
                     r_state <= S_DATA;
                     r_txd   <= r_data[0];
                  end
                  S_DATA: begin
                     if (w_last) begin
                        r_state <= r_pen ? S_PARITY : S_STOP1;
                        r_txd   <= r_pen ? w_par : 1'b1;
                     end else begin
                        r_bit <= r_bit + 3'd1;
                        r_txd <= r_data[r_bit + 3'd1];
                     end
                  end
                  S_PARITY: begin
                     r_state <= S_STOP1;
                     r_txd   <= 1'b1;
                  end
                  S_STOP1: begin
                     if (r_stp2) begin
                        r_state <= S_STOP2;
                        r_txd   <= 1'b1;
                     end else begin
                        r_state <= S_IDLE;
                        r_txd   <= ~i_brk;
                        r_done  <= 1'b1;
                     end
                  end
                  S_STOP2: begin
                     r_state <= S_IDLE;
                     r_txd   <= ~i_brk;
                     r_done  <= 1'b1;
                  end
                  default: r_state <= S_IDLE;
               endcase
            end
         end
      end
   end

   assign UARTTXD = r_txd;
   assign o_done  = r_done;
   assign o_busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Bench for uart_tx_engine: a frame-level model (frame bit list plus a
// closed-form tick schedule) is checked against the DUT every cycle, and
// literal timing/bit expectations pin the model for the directed cases.
module tb_uart_tx_engine;

   logic        UARTCLK = 1'b0;
   logic        nUARTRST = 1'b0;
   logic        i_en = 1'b1;
   logic [15:0] i_ibrd = 16'd1;
   logic [5:0]  i_fbrd = 6'd0;
   logic [1:0]  i_wlen = 2'd3;
   logic        i_pen = 1'b0, i_eps = 1'b0, i_sps = 1'b0, i_stp2 = 1'b0;
   logic        i_brk = 1'b0;
   logic        s_valid = 1'b0;
   logic [7:0]  s_data = 8'h00;
   logic        s_ready, UARTTXD, o_busy, o_done;

   uart_tx_engine dut (
      .UARTCLK(UARTCLK), .nUARTRST(nUARTRST), .i_en(i_en),
      .i_ibrd(i_ibrd), .i_fbrd(i_fbrd), .i_wlen(i_wlen), .i_pen(i_pen),
      .i_eps(i_eps), .i_sps(i_sps), .i_stp2(i_stp2), .i_brk(i_brk),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .UARTTXD(UARTTXD), .o_busy(o_busy), .o_done(o_done)
   );

   always #5 UARTCLK = ~UARTCLK;

   int cyc = 0;
   always @(posedge UARTCLK) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
      n_chk++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, a, e);
      end
   endtask

   // ---------------- model ----------------
   logic        m_active = 1'b0;
   int          m_off = 0, m_nb = 0, m_ib = 1, m_fb = 0;
   logic [11:0] m_frame = '0;
   logic        e_txd = 1'b1, e_busy = 1'b0, e_done = 1'b0;

   // Clock offset (from the transfer cycle) of the j-th baud16 tick.
   function automatic int tick_t(int j, int ib, int fb);
      if (j == 0) return 0;
      return j * ib + ((j - 1) * fb) / 64;
   endfunction

   function automatic int frame_len(logic [1:0] wl, logic pen, logic stp2);
      return 1 + 5 + int'(wl) + int'(pen) + 1 + int'(stp2);
   endfunction

   function automatic logic [11:0] frame_bits(logic [7:0] d, logic [1:0] wl,
         logic pen, logic eps, logic sps, logic stp2);
      logic [11:0] f;
      int nd, ones, n;
      f = '1;
      nd = 5 + int'(wl);
      ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < nd; i++) begin
         f[1 + i] = d[i];
         ones += int'(d[i]);
      end
      n = 1 + nd;
      if (pen) begin
         if (sps)      f[n] = ~eps;
         else if (eps) f[n] = (ones % 2 == 1);
         else          f[n] = (ones % 2 == 0);
         n++;
      end
      f[n] = 1'b1;
      if (stp2) f[n + 1] = 1'b1;
      return f;
   endfunction

   function automatic logic bit_at(int o);
      for (int b = 0; b < m_nb; b++)
         if (o <= tick_t(16 * (b + 1), m_ib, m_fb)) return m_frame[b];
      return 1'b1;
   endfunction

   function automatic logic exp_ready();
      return nUARTRST && !m_active && i_en && !i_brk && (i_ibrd != 16'd0);
   endfunction

   always @(posedge UARTCLK) begin
      if (!nUARTRST) begin
         m_active <= 1'b0;
         e_txd    <= 1'b1;
         e_busy   <= 1'b0;
         e_done   <= 1'b0;
      end else if (m_active) begin
         if (m_off + 1 > tick_t(16 * m_nb, m_ib, m_fb)) begin
            m_active <= 1'b0;
            e_done   <= 1'b1;
            e_busy   <= 1'b0;
            e_txd    <= ~i_brk;
         end else begin
            m_off  <= m_off + 1;
            e_txd  <= bit_at(m_off + 1);
            e_busy <= 1'b1;
            e_done <= 1'b0;
         end
      end else begin
         e_done <= 1'b0;
         if (s_valid && exp_ready()) begin
            m_frame  <= frame_bits(s_data, i_wlen, i_pen, i_eps, i_sps, i_stp2);
            m_nb     <= frame_len(i_wlen, i_pen, i_stp2);
            m_ib     <= int'(i_ibrd);
            m_fb     <= int'(i_fbrd);
            m_off    <= 1;
            m_active <= 1'b1;
            e_txd    <= 1'b0;
            e_busy   <= 1'b1;
         end else begin
            e_txd  <= ~i_brk;
            e_busy <= 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare + trace ----------------
   logic txd_log [0:8191];
   logic done_log[0:8191];
   logic rdy_log [0:8191];
   logic busy_log[0:8191];

   always @(posedge UARTCLK) begin
      #1;
      chk("txd",   UARTTXD, e_txd);
      chk("busy",  o_busy,  e_busy);
      chk("done",  o_done,  e_done);
      chk("ready", s_ready, exp_ready());
      if (cyc < 8192) begin
         txd_log[cyc]  = UARTTXD;
         done_log[cyc] = o_done;
         rdy_log[cyc]  = s_ready;
         busy_log[cyc] = o_busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cfg(int ib, int fb, logic [1:0] wl, logic pen, logic eps,
                      logic sps, logic stp2);
      @(negedge UARTCLK);
      i_ibrd = 16'(ib); i_fbrd = 6'(fb); i_wlen = wl;
      i_pen = pen; i_eps = eps; i_sps = sps; i_stp2 = stp2;
   endtask

   task automatic send(input logic [7:0] d, output int k);
      bit got;
      got = 0;
      k = 0;
      @(negedge UARTCLK);
      s_valid = 1'b1;
      s_data  = d;
      #1;
      for (int i = 0; i < 2000; i++) begin
         if (s_ready) begin
            k = cyc;
            got = 1;
            break;
         end
         @(negedge UARTCLK);
         #1;
      end
      if (!got) chk("send_timeout", 0, 1);
      @(negedge UARTCLK);
      s_valid = 1'b0;
      s_data  = ~d;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 5000; i++) begin
         @(negedge UARTCLK);
         if (!o_busy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) chk("idle_timeout", 0, 1);
   endtask

   task automatic wait_cyc(int t);
      while (cyc < t) @(negedge UARTCLK);
   endtask

   initial begin
      int k, k2, c, cnt;

      // reset state
      s_valid = 1'b1;
      repeat (3) @(negedge UARTCLK);
      chk("rst_txd", UARTTXD, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", s_ready, 0);
      chk("rst_done", o_done, 0);
      s_valid = 1'b0;
      nUARTRST = 1'b1;
      @(negedge UARTCLK);

      // 8N1, IBRD=1, 0x55
      send(8'h55, k);
      wait_idle();
      chk("55_start_a", txd_log[k+1], 0);
      chk("55_start_b", txd_log[k+16], 0);
      chk("55_d0", txd_log[k+17], 1);
      chk("55_d1", txd_log[k+33], 0);
      chk("55_d7", txd_log[k+144], 0);
      chk("55_stop", txd_log[k+145], 1);
      chk("55_nodone160", done_log[k+160], 0);
      chk("55_done161", done_log[k+161], 1);

      // 7E1, 0x41
      cfg(1, 0, 2'd2, 1, 1, 0, 0);
      send(8'h41, k);
      wait_idle();
      chk("41_d0", txd_log[k+17], 1);
      chk("41_d1", txd_log[k+33], 0);
      chk("41_d6", txd_log[k+113], 1);
      chk("41_par", txd_log[k+129], 0);
      chk("41_done161", done_log[k+161], 1);

      // IBRD=2, FBRD=32, 8N1; format inputs change mid-frame
      cfg(2, 32, 2'd3, 0, 0, 0, 0);
      send(8'hA3, k);
      wait_cyc(k + 50);
      i_wlen = 2'd0; i_ibrd = 16'd5; i_pen = 1'b1;
      wait_idle();
      chk("frac_nodone399", done_log[k+399], 0);
      chk("frac_done400", done_log[k+400], 1);

      // back-to-back, 8N1 IBRD=1
      cfg(1, 0, 2'd3, 0, 0, 0, 0);
      send(8'h0F, k);
      send(8'hF0, k2);
      chk("b2b_gap", k2 - k, 161);
      chk("b2b_idle_hi", txd_log[k+161], 1);
      wait_idle();
      chk("b2b_start2", txd_log[k2+1], 0);
      chk("b2b_done2", done_log[k2+161], 1);

      // break raised during data bit 3
      send(8'h00, k);
      wait_cyc(k + 70);
      i_brk = 1'b1;
      wait_idle();
      chk("brk_done", done_log[k+161], 1);
      chk("brk_txd", txd_log[k+161], 0);
      chk("brk_ready", rdy_log[k+161], 0);
      repeat (5) @(negedge UARTCLK);
      c = cyc;
      i_brk = 1'b0;
      repeat (3) @(negedge UARTCLK);
      chk("brk_rel_txd", txd_log[c+1], 1);
      chk("brk_rel_ready", rdy_log[c+1], 1);

      // 5O2 stick parity, reset during data bit 2
      cfg(1, 0, 2'd0, 1, 0, 1, 1);
      send(8'h1B, k);
      wait_cyc(k + 55);
      nUARTRST = 1'b0;
      @(negedge UARTCLK);
      nUARTRST = 1'b1;
      repeat (200) @(negedge UARTCLK);
      chk("rst_mid_txd", txd_log[k+56], 1);
      chk("rst_mid_busy", busy_log[k+56], 0);
      cnt = 0;
      for (int i = k + 50; i < k + 250; i++) cnt += int'(done_log[i]);
      chk("rst_mid_nodone", cnt, 0);
      send(8'h0A, k);
      wait_idle();
      chk("5o2_d1", txd_log[k+33], 1);
      chk("5o2_par", txd_log[k+97], 1);
      chk("5o2_stop2", txd_log[k+129], 1);
      chk("5o2_done145", done_log[k+145], 1);

      // enable dropped mid-frame
      cfg(1, 0, 2'd3, 0, 0, 0, 0);
      send(8'h3C, k);
      wait_cyc(k + 40);
      i_en = 1'b0;
      wait_idle();
      repeat (5) @(negedge UARTCLK);
      chk("en_done", done_log[k+161], 1);
      chk("en_ready_low", rdy_log[k+165], 0);
      c = cyc;
      i_en = 1'b1;
      repeat (2) @(negedge UARTCLK);
      chk("en_ready_back", rdy_log[c+1], 1);

      // IBRD=0: no transfer possible
      cfg(0, 0, 2'd3, 0, 0, 0, 0);
      c = cyc;
      s_valid = 1'b1;
      repeat (20) @(negedge UARTCLK);
      s_valid = 1'b0;
      chk("ibrd0_busy", busy_log[c+10], 0);
      chk("ibrd0_ready", rdy_log[c+10], 0);

      // 6O2, IBRD=3, FBRD=5
      cfg(3, 5, 2'd1, 1, 0, 0, 1);
      send(8'h2D, k);
      wait_idle();
      chk("6o2_nodone492", done_log[k+492], 0);
      chk("6o2_done493", done_log[k+493], 1);

      repeat (3) @(negedge UARTCLK);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
